// File: rtl/retire_unit_wide.sv
// In-order multi-wide retirement stage: strict-prefix retire, free-list return, store commit, flush and halt sequencing.
// Optional stall statistics counters are enabled with `define RETIRE_STALL_CNT_EN.
module retire_unit_wide #(
  parameter int RET_WIDTH = 4,
  parameter int PRF_SZ    = 64,
  parameter int PRF_IDX_W = $clog2(PRF_SZ),
  parameter int CNT_W     = $clog2(RET_WIDTH + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CNT_W-1:0]               head_count,
  input  logic [RET_WIDTH*PRF_IDX_W-1:0] head_t_new,
  input  logic [RET_WIDTH*PRF_IDX_W-1:0] head_t_old,
  input  logic [RET_WIDTH-1:0]           head_has_dest,
  input  logic [RET_WIDTH-1:0]           head_is_store,
  input  logic [RET_WIDTH-1:0]           head_mispred,
  input  logic [RET_WIDTH-1:0]           head_halt,
  input  logic [RET_WIDTH*32-1:0]        head_npc,
  input  logic [RET_WIDTH*5-1:0]         head_arch_reg,
  input  logic [PRF_SZ-1:0]              complete_vec,
  output logic [RET_WIDTH*PRF_IDX_W-1:0] rf_read_idx,
  input  logic [RET_WIDTH*32-1:0]        rf_read_data,
  output logic [CNT_W-1:0]               num_retiring,
  output logic [RET_WIDTH-1:0]           free_valid,
  output logic [RET_WIDTH*PRF_IDX_W-1:0] free_idx,
  output logic                           sq_commit_valid,
  input  logic                           sq_commit_ready,
  output logic [RET_WIDTH-1:0]           commit_valid,
  output logic [RET_WIDTH*32-1:0]        commit_data,
  output logic [RET_WIDTH*5-1:0]         commit_reg,
  output logic [RET_WIDTH*32-1:0]        commit_npc,
  output logic [RET_WIDTH-1:0]           commit_halt,
  output logic                           flush,
  output logic                           halted,
  output logic [63:0]                    retired_count
`ifdef RETIRE_STALL_CNT_EN
  ,
  output logic [31:0]                    stall_incomplete_cnt,
  output logic [31:0]                    stall_store_cnt
`endif
);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

  state_t                 state;
  logic                   go;
  logic                   store_seen;
  logic                   slot_ok;
  logic                   halt_ret;
  logic                   mispred_ret;
  logic [PRF_IDX_W-1:0]   t_new_i;
  logic [CNT_W-1:0]       n_ret;
  int                     fpos;

  assign rf_read_idx     = head_t_new;
  assign num_retiring    = n_ret;
  assign sq_commit_valid = store_seen;

  // Walk slots oldest-first; the first slot that cannot retire closes the prefix.
  always_comb begin
    go           = (state == S_RUN);
    store_seen   = 1'b0;
    slot_ok      = 1'b0;
    halt_ret     = 1'b0;
    mispred_ret  = 1'b0;
    t_new_i      = '0;
    n_ret        = '0;
    fpos         = 0;
    free_valid   = '0;
    free_idx     = '0;
    commit_valid = '0;
    commit_data  = '0;
    commit_reg   = '0;
    commit_npc   = '0;
    commit_halt  = '0;
    for (int i = 0; i < RET_WIDTH; i++) begin
      t_new_i = head_t_new[i*PRF_IDX_W +: PRF_IDX_W];
      slot_ok = go && (i < int'(head_count)) && complete_vec[t_new_i] &&
                !(head_is_store[i] && (store_seen || !sq_commit_ready));
      if (slot_ok) begin
        n_ret           = n_ret + CNT_W'(1);
        commit_valid[i] = 1'b1;
        commit_data[i*32 +: 32] = rf_read_data[i*32 +: 32];
        commit_npc[i*32 +: 32]  = head_npc[i*32 +: 32];
        commit_halt[i]  = head_halt[i];
        if (head_has_dest[i]) begin
          commit_reg[i*5 +: 5] = head_arch_reg[i*5 +: 5];
          free_valid[fpos]     = 1'b1;
          free_idx[fpos*PRF_IDX_W +: PRF_IDX_W] = head_t_old[i*PRF_IDX_W +: PRF_IDX_W];
          fpos = fpos + 1;
        end
        if (head_is_store[i]) store_seen = 1'b1;
        // Halt takes priority over a mispredict on the same slot.
        if (head_halt[i]) begin
          halt_ret = 1'b1;
          go       = 1'b0;
        end else if (head_mispred[i]) begin
          mispred_ret = 1'b1;
          go          = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_RUN;
      flush         <= 1'b0;
      halted        <= 1'b0;
      retired_count <= '0;
    end else begin
      case (state)
        S_RUN: begin
          retired_count <= retired_count + 64'(n_ret);
          if (halt_ret) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (mispred_ret) begin
            state <= S_FLUSH;
            flush <= 1'b1;
          end
        end
        S_FLUSH: begin
          state <= S_RUN;
          flush <= 1'b0;
        end
        default: begin
          state  <= S_HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

`ifdef RETIRE_STALL_CNT_EN
  // Attribute cycles where the head is present but nothing leaves; counters saturate.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_incomplete_cnt <= '0;
      stall_store_cnt      <= '0;
    end else if (state == S_RUN && head_count != '0 && n_ret == '0) begin
      if (!complete_vec[head_t_new[0 +: PRF_IDX_W]] && stall_incomplete_cnt != '1)
        stall_incomplete_cnt <= stall_incomplete_cnt + 32'd1;
      if (head_is_store[0] && !sq_commit_ready && stall_store_cnt != '1)
        stall_store_cnt <= stall_store_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_retire_unit_wide.sv
// Self-checking bench for retire_unit_wide: directed scenarios then randomized heads against a queue-based reference model.
module tb_retire_unit_wide;

  localparam int RW = 4;
  localparam int IW = 6;

  logic           clock = 1'b0;
  logic           reset;
  logic [2:0]     head_count;
  logic [RW*IW-1:0] head_t_new, head_t_old;
  logic [RW-1:0]  head_has_dest, head_is_store, head_mispred, head_halt;
  logic [RW*32-1:0] head_npc;
  logic [RW*5-1:0]  head_arch_reg;
  logic [63:0]    complete_vec;
  logic [RW*IW-1:0] rf_read_idx;
  logic [RW*32-1:0] rf_read_data;
  logic [2:0]     num_retiring;
  logic [RW-1:0]  free_valid;
  logic [RW*IW-1:0] free_idx;
  logic           sq_commit_valid, sq_commit_ready;
  logic [RW-1:0]  commit_valid;
  logic [RW*32-1:0] commit_data;
  logic [RW*5-1:0]  commit_reg;
  logic [RW*32-1:0] commit_npc;
  logic [RW-1:0]  commit_halt;
  logic           flush, halted;
  logic [63:0]    retired_count;

  retire_unit_wide dut (
    .clock(clock), .reset(reset), .head_count(head_count),
    .head_t_new(head_t_new), .head_t_old(head_t_old), .head_has_dest(head_has_dest),
    .head_is_store(head_is_store), .head_mispred(head_mispred), .head_halt(head_halt),
    .head_npc(head_npc), .head_arch_reg(head_arch_reg), .complete_vec(complete_vec),
    .rf_read_idx(rf_read_idx), .rf_read_data(rf_read_data), .num_retiring(num_retiring),
    .free_valid(free_valid), .free_idx(free_idx), .sq_commit_valid(sq_commit_valid),
    .sq_commit_ready(sq_commit_ready), .commit_valid(commit_valid), .commit_data(commit_data),
    .commit_reg(commit_reg), .commit_npc(commit_npc), .commit_halt(commit_halt),
    .flush(flush), .halted(halted), .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  // Per-slot stimulus fields
  logic [IW-1:0] tn [RW];
  logic [IW-1:0] to [RW];
  logic [31:0]   npc [RW];
  logic [31:0]   dat [RW];
  logic [4:0]    arch [RW];
  logic          hd [RW];
  logic          st [RW];
  logic          mp [RW];
  logic          hl [RW];
  int            hc;

  // Reference model state
  typedef enum int {M_RUN, M_FLUSH, M_HALT} mstate_t;
  mstate_t     mstate;
  logic [63:0] m_count;
  int          exp_n;
  bit          exp_halt_hit, exp_mp_hit;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic setDefault(input int count);
    hc = count;
    for (int i = 0; i < RW; i++) begin
      tn[i] = IW'(8 + i);  to[i] = IW'(20 + i);
      npc[i] = 32'h1000 + 32'(4 * i);  dat[i] = 32'hA000_0000 + 32'(i);
      arch[i] = 5'(3 + i);  hd[i] = 1'b1;
      st[i] = 1'b0;  mp[i] = 1'b0;  hl[i] = 1'b0;
    end
    complete_vec    = '1;
    sq_commit_ready = 1'b1;
  endtask

  task automatic randomize_heads();
    hc = $urandom_range(0, RW);
    for (int i = 0; i < RW; i++) begin
      tn[i] = IW'($urandom_range(0, 63));  to[i] = IW'($urandom_range(0, 63));
      npc[i] = $urandom;  dat[i] = $urandom;  arch[i] = 5'($urandom);
      hd[i] = ($urandom_range(0, 3) != 0);
      st[i] = ($urandom_range(0, 3) == 0);
      mp[i] = ($urandom_range(0, 7) == 0);
      hl[i] = ($urandom_range(0, 31) == 0);
    end
    complete_vec    = ~({$urandom, $urandom} & {$urandom, $urandom});
    sq_commit_ready = ($urandom_range(0, 3) != 0);
    reset           = ($urandom_range(0, 29) == 0);
  endtask

  // Pack per-slot fields onto the DUT buses and let them settle toward mid-cycle.
  task automatic applyStimulus();
    head_count = 3'(hc);
    for (int i = 0; i < RW; i++) begin
      head_t_new[i*IW +: IW] = tn[i];  head_t_old[i*IW +: IW] = to[i];
      head_npc[i*32 +: 32] = npc[i];  rf_read_data[i*32 +: 32] = dat[i];
      head_arch_reg[i*5 +: 5] = arch[i];
      head_has_dest[i] = hd[i];  head_is_store[i] = st[i];
      head_mispred[i] = mp[i];  head_halt[i] = hl[i];
    end
    #4;
  endtask

  // Model the cycle: retire oldest-first until a slot fails any rule, then compare everything.
  task automatic checkOutput();
    logic [IW-1:0] freed[$];
    logic [RW-1:0] e_cv, e_ch, e_fv;
    logic [RW*32-1:0] e_cd, e_cn;
    logic [RW*5-1:0]  e_cr;
    logic [RW*IW-1:0] e_fi, e_ri;
    bit stores_done, blocked;
    e_cv = '0; e_ch = '0; e_fv = '0; e_cd = '0; e_cn = '0; e_cr = '0; e_fi = '0; e_ri = '0;
    exp_n = 0; exp_halt_hit = 0; exp_mp_hit = 0; stores_done = 0;
    blocked = (mstate != M_RUN);
    for (int i = 0; i < RW; i++) begin
      e_ri[i*IW +: IW] = tn[i];
      if (i >= hc || !complete_vec[tn[i]]) blocked = 1;
      if (st[i] && (stores_done || !sq_commit_ready)) blocked = 1;
      if (!blocked) begin
        exp_n++;
        e_cv[i] = 1'b1;  e_ch[i] = hl[i];
        e_cd[i*32 +: 32] = dat[i];  e_cn[i*32 +: 32] = npc[i];
        if (hd[i]) begin
          e_cr[i*5 +: 5] = arch[i];
          freed.push_back(to[i]);
        end
        if (st[i]) stores_done = 1;
        if (hl[i]) exp_halt_hit = 1;
        else if (mp[i]) exp_mp_hit = 1;
        if (hl[i] || mp[i]) blocked = 1;
      end
    end
    foreach (freed[k]) begin
      e_fv[k] = 1'b1;
      e_fi[k*IW +: IW] = freed[k];
    end
    check("num_retiring", 256'(num_retiring), 256'(exp_n));
    check("commit_valid", 256'(commit_valid), 256'(e_cv));
    check("commit_data", 256'(commit_data), 256'(e_cd));
    check("commit_reg", 256'(commit_reg), 256'(e_cr));
    check("commit_npc", 256'(commit_npc), 256'(e_cn));
    check("commit_halt", 256'(commit_halt), 256'(e_ch));
    check("free_valid", 256'(free_valid), 256'(e_fv));
    check("free_idx", 256'(free_idx), 256'(e_fi));
    check("sq_commit_valid", 256'(sq_commit_valid), 256'(stores_done));
    check("rf_read_idx", 256'(rf_read_idx), 256'(e_ri));
    check("flush", 256'(flush), 256'(mstate == M_FLUSH));
    check("halted", 256'(halted), 256'(mstate == M_HALT));
    check("retired_count", 256'(retired_count), 256'(m_count));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (reset) begin
      mstate  = M_RUN;
      m_count = '0;
    end else begin
      case (mstate)
        M_RUN: begin
          m_count = m_count + 64'(exp_n);
          if (exp_halt_hit) mstate = M_HALT;
          else if (exp_mp_hit) mstate = M_FLUSH;
        end
        M_FLUSH: mstate = M_RUN;
        default: mstate = M_HALT;
      endcase
    end
  endtask

  task automatic cycle();
    applyStimulus();
    checkOutput();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    mstate = M_RUN;
    m_count = '0;
    exp_n = 0; exp_halt_hit = 0; exp_mp_hit = 0;
    setDefault(0);
    applyStimulus();
    @(posedge clock); #1;
    cycle();
    reset = 1'b0;

    $display("[TB] full-width retire");
    setDefault(4);
    applyStimulus(); checkOutput();
    check("tp1_nret", 256'(num_retiring), 256'(4));
    check("tp1_free_valid", 256'(free_valid), 256'(4'b1111));
    check("tp1_free_idx", 256'(free_idx), 256'({6'd23, 6'd22, 6'd21, 6'd20}));
    tick();
    setDefault(0);
    applyStimulus(); checkOutput();
    check("tp1_count", 256'(retired_count), 256'(4));
    tick();

    $display("[TB] incomplete slot 2");
    setDefault(4);
    complete_vec[tn[2]] = 1'b0;
    applyStimulus(); checkOutput();
    check("tp2_nret", 256'(num_retiring), 256'(2));
    check("tp2_cv", 256'(commit_valid), 256'(4'b0011));
    tick();

    $display("[TB] two stores");
    setDefault(4);
    st[0] = 1'b1; st[2] = 1'b1;
    applyStimulus(); checkOutput();
    check("tp3_nret", 256'(num_retiring), 256'(2));
    check("tp3_sq", 256'(sq_commit_valid), 256'(1));
    tick();
    sq_commit_ready = 1'b0;
    applyStimulus(); checkOutput();
    check("tp3_nret_nrdy", 256'(num_retiring), 256'(0));
    tick();

    $display("[TB] mispredict on slot 1");
    setDefault(4);
    mp[1] = 1'b1;
    applyStimulus(); checkOutput();
    check("tp4_nret", 256'(num_retiring), 256'(2));
    tick();
    setDefault(4);
    applyStimulus(); checkOutput();
    check("tp4_flush", 256'(flush), 256'(1));
    check("tp4_nret_flush", 256'(num_retiring), 256'(0));
    tick();
    applyStimulus(); checkOutput();
    check("tp4_flush_clr", 256'(flush), 256'(0));
    check("tp4_nret_run", 256'(num_retiring), 256'(4));
    tick();

    $display("[TB] halt on slot 0");
    setDefault(3);
    hl[0] = 1'b1;
    applyStimulus(); checkOutput();
    check("tp5_nret", 256'(num_retiring), 256'(1));
    check("tp5_chalt", 256'(commit_halt[0]), 256'(1));
    tick();
    setDefault(4);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(); checkOutput();
      check("tp5_halted", 256'(halted), 256'(1));
      check("tp5_nret_halt", 256'(num_retiring), 256'(0));
      tick();
    end
    reset = 1'b1; cycle(); reset = 1'b0;

    $display("[TB] halt and mispredict on same slot");
    setDefault(4);
    hl[1] = 1'b1; mp[1] = 1'b1;
    cycle();
    setDefault(4);
    applyStimulus(); checkOutput();
    check("hm_halted", 256'(halted), 256'(1));
    check("hm_flush", 256'(flush), 256'(0));
    tick();
    reset = 1'b1; cycle(); reset = 1'b0;

    $display("[TB] reset during flush");
    setDefault(4);
    mp[0] = 1'b1;
    cycle();
    setDefault(4);
    reset = 1'b1;
    applyStimulus(); checkOutput();
    check("tp6_in_flush", 256'(flush), 256'(1));
    tick();
    reset = 1'b0;
    applyStimulus(); checkOutput();
    check("tp6_flush", 256'(flush), 256'(0));
    check("tp6_halted", 256'(halted), 256'(0));
    check("tp6_count", 256'(retired_count), 256'(0));
    check("tp6_nret", 256'(num_retiring), 256'(4));
    tick();

    $display("[TB] randomized heads");
    for (int r = 0; r < 500; r++) begin
      randomize_heads();
      cycle();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/retire_unit_wide.md
Name: retire_unit_wide

Overview:
Parametrised in-order retirement stage between ROB head and architectural commit. Retires up to RET_WIDTH completed head entries per cycle and returns freed physical registers to the free list. Adds three things over single-mode retirement: a store-commit handshake to the store queue, branch-mispredict flush sequencing, and a terminal halt state. Commit packets go to the CPU trace/writeback port.

Parameters:
RET_WIDTH, 4, maximum instructions retired per cycle (1..8)
PRF_SZ, 64, physical register count; PRF_IDX_W = clog2(PRF_SZ)
CNT_W, clog2(RET_WIDTH+1), width of count fields

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
head_count  in  CNT_W  valid ROB entries presented at head, 0..RET_WIDTH; slot 0 = oldest
head_t_new  in  RET_WIDTH*PRF_IDX_W  destination physical reg per slot
head_t_old  in  RET_WIDTH*PRF_IDX_W  previous mapping per slot
head_has_dest  in  RET_WIDTH  slot writes a register
head_is_store  in  RET_WIDTH  slot is a store
head_mispred  in  RET_WIDTH  slot is a resolved mispredicted branch
head_halt  in  RET_WIDTH  slot is a halt
head_npc  in  RET_WIDTH*32  next PC per slot
head_arch_reg  in  RET_WIDTH*5  architectural destination per slot
complete_vec  in  PRF_SZ  completion bit per physical reg
rf_read_idx  out  RET_WIDTH*PRF_IDX_W  regfile read index (= head_t_new)
rf_read_data  in  RET_WIDTH*32  regfile read data, same cycle
num_retiring  out  CNT_W  entries popped from ROB this cycle
free_valid  out  RET_WIDTH  compacted valid mask of freed regs (low bits first)
free_idx  out  RET_WIDTH*PRF_IDX_W  compacted freed T_old values
sq_commit_valid  out  1  a store retires this cycle
sq_commit_ready  in  1  store queue accepts commit
commit_valid  out  RET_WIDTH  per-slot commit packet valid
commit_data  out  RET_WIDTH*32  rf_read_data of retired slot
commit_reg  out  RET_WIDTH*5  arch reg, 0 if !has_dest
commit_npc  out  RET_WIDTH*32  NPC
commit_halt  out  RET_WIDTH  halt flag
flush  out  1  registered; pipeline flush after mispredict retire
halted  out  1  registered; terminal halt reached
retired_count  out  64  registered total instructions retired

Behaviour:
- FSM states: RUN, FLUSH, HALT. On reset: RUN; flush=0, halted=0, retired_count=0. All combinational outputs are 0 whenever state != RUN or no slot retires.
- RUN, slot i retires iff all of:
  - i < head_count
  - slots 0..i-1 retire
  - complete_vec[t_new[i]] = 1
  - no earlier slot this cycle was halt or mispred
  - if is_store: no earlier store retired this cycle and sq_commit_ready = 1
- First failing slot stops retirement (strict prefix).
- num_retiring = prefix length. commit_* driven for retiring slots only.
- rf_read_idx[i] = head_t_new[i] always.
- Freeing: free entries are retiring slots with has_dest, compacted in order; non-dest slots free nothing.
- sq_commit_valid = 1 iff a store slot retires. At most one store retires per cycle; the second store stops the prefix.
- Mispred slot retires itself (inclusive), then next state = FLUSH.
  - FLUSH: flush=1 for exactly one cycle, retires nothing, returns to RUN.
  - Redirect target is supplied by the branch unit, not this block.
- Halt slot retires itself (inclusive), then next state = HALT. halted=1 and nothing retires until reset.
- Halt and mispred on the same slot: HALT wins, no flush.
- retired_count += num_retiring each cycle, wrapping at 2^64.
- Reset asserted in any state: returns to RUN the next edge; all registered outputs cleared.

Optional Feature:
RETIRE_STALL_CNT_EN.
- Defined: adds outputs stall_incomplete_cnt (32) and stall_store_cnt (32), both reset to 0.
  - In RUN with head_count>0 and num_retiring=0: incomplete head increments stall_incomplete_cnt; head store with sq_commit_ready=0 increments stall_store_cnt.
  - Both saturate at 2^32-1.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- head_count=4, all complete, no stores/branches -> num_retiring=4, free_valid=4'b1111 with T_old in order, retired_count +4 next cycle.
- Slots 0,1 complete, slot 2 incomplete, slot 3 complete -> num_retiring=2, commit_valid=4'b0011.
- Slots 0 and 2 stores, all complete, sq_commit_ready=1 -> num_retiring=2, sq_commit_valid=1. With ready=0 -> num_retiring=0.
- Slot 1 mispred, head_count=4, all complete -> num_retiring=2; next cycle flush=1, num_retiring=0; the cycle after, flush=0 and state RUN.
- Slot 0 halt, head_count=3 -> num_retiring=1, commit_halt[0]=1; halted=1 next cycle; later valid heads give num_retiring=0 until reset.
- Reset asserted during FLUSH -> next cycle flush=0, halted=0, retired_count=0, retirement resumes.
